// File: rtl/audio_pdm_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pdm_out
//  Description : Output sink for the synth voice path. Latches an unsigned
//                BITDEPTH-bit sample on every rising edge of sample_clock,
//                scales it about midscale by a linear mute/unmute gain ramp,
//                and converts the result to a 1-bit first-order sigma-delta
//                PDM stream for the speaker pin.
//  Ports       : clk           - system clock
//                rst           - asynchronous, active-high reset
//                sample_clock  - sample-rate level, rising edge = new sample
//                sample_in     - unsigned sample, captured on the detected rise
//                enable        - 1 = ramp to unity gain, 0 = ramp to mute
//                pdm_out       - registered PDM bitstream
//                sample_strobe - 1-clk pulse the cycle after a rise is seen
//                state         - 0 MUTED, 1 RAMP_UP, 2 PLAYING, 3 RAMP_DOWN
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pdm_out #(
  parameter int BITDEPTH = 14,
  parameter int GAINBITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clock,
  input  logic [BITDEPTH-1:0] sample_in,
  input  logic                enable,
  output logic                pdm_out,
  output logic                sample_strobe,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_MUTED     = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_PLAYING   = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  // Product of a centred sample (|c| <= 2**(BITDEPTH-1)) and a gain
  // (<= 2**GAINBITS) always fits in BITDEPTH+GAINBITS signed bits.
  localparam int PW = BITDEPTH + GAINBITS;

  localparam logic [BITDEPTH-1:0] c_MID   = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [GAINBITS:0]   c_UNITY = {1'b1, {GAINBITS{1'b0}}};
  localparam logic [GAINBITS:0]   c_ONE   = (GAINBITS+1)'(1);

  logic                sc_q;
  logic [BITDEPTH-1:0] sample_q;
  logic [GAINBITS:0]   gain_q,  gain_d;
  state_t              state_q, state_d;
  logic [BITDEPTH-1:0] acc_q;
  logic                pdm_q;
  logic                strobe_q;

  logic                       w_tick;
  logic [GAINBITS:0]          w_gain_up;
  logic [GAINBITS:0]          w_gain_dn;
  logic signed [BITDEPTH:0]   w_centered;
  logic signed [GAINBITS+1:0] w_gain_s;
  logic signed [PW-1:0]       w_prod;
  logic signed [BITDEPTH-1:0] w_scaled;
  logic [BITDEPTH-1:0]        w_dac;
  logic [BITDEPTH:0]          w_sum;

  // A held-high sample_clock yields exactly one tick.
  assign w_tick = sample_clock & ~sc_q;

  // Saturating gain steps: never above unity, never below zero.
  assign w_gain_up = (gain_q == c_UNITY) ? c_UNITY : gain_q + c_ONE;
  assign w_gain_dn = (gain_q == '0)      ? '0      : gain_q - c_ONE;

  // ---------------------------------------------------------------------------
  // Gain ramp FSM. State can change on any clk; gain only moves on a tick.
  // A direction reversal takes effect immediately, so the tick that coincides
  // with it already steps the gain the new way.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      S_MUTED: begin
        gain_d = '0;
        if (enable) state_d = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (!enable) begin
          state_d = S_RAMP_DOWN;
          if (w_tick) begin
            gain_d = w_gain_dn;
            if (w_gain_dn == '0) state_d = S_MUTED;
          end
        end else if (w_tick) begin
          gain_d = w_gain_up;
          if (w_gain_up == c_UNITY) state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        gain_d = c_UNITY;
        if (!enable) state_d = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (enable) begin
          state_d = S_RAMP_UP;
          if (w_tick) begin
            gain_d = w_gain_up;
            if (w_gain_up == c_UNITY) state_d = S_PLAYING;
          end
        end else if (w_tick) begin
          gain_d = w_gain_dn;
          if (w_gain_dn == '0) state_d = S_MUTED;
        end
      end
      default: begin
        state_d = S_MUTED;
        gain_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Gain scaling about midscale. Unity gain is a pure shift, so the sample
  // passes through bit-exact; zero gain lands exactly on midscale.
  // ---------------------------------------------------------------------------
  assign w_centered = signed'({1'b0, sample_q} - {1'b0, c_MID});
  assign w_gain_s   = signed'({1'b0, gain_q});
  assign w_prod     = PW'(w_centered) * PW'(w_gain_s);
  assign w_scaled   = BITDEPTH'(w_prod >>> GAINBITS);
  assign w_dac      = $unsigned(w_scaled) + c_MID;

  // First-order modulator: the accumulator carry is the output bit.
  assign w_sum = {1'b0, acc_q} + {1'b0, w_dac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q     <= 1'b0;
      sample_q <= c_MID;
      gain_q   <= '0;
      state_q  <= S_MUTED;
      acc_q    <= '0;
      pdm_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sc_q     <= sample_clock;
      if (w_tick) sample_q <= sample_in;
      strobe_q <= w_tick;
      gain_q   <= gain_d;
      state_q  <= state_d;
      acc_q    <= w_sum[BITDEPTH-1:0];
      pdm_q    <= w_sum[BITDEPTH];
    end
  end

  assign pdm_out       = pdm_q;
  assign sample_strobe = strobe_q;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_pdm_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pdm_out
//  Description : Self-checking bench for audio_pdm_out. Each generated
//                sample_clock rise queues the state expected after its tick;
//                a monitor pops and compares on every sample_strobe. PDM
//                densities and reset behaviour are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pdm_out;

  localparam int BD = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_clock;
  logic [BD-1:0] sample_in;
  logic          enable;
  logic          pdm_out;
  logic          sample_strobe;
  logic [1:0]    state;

  always #5 clk = ~clk;

  audio_pdm_out #(.BITDEPTH(BD), .GAINBITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_clock  (sample_clock),
    .sample_in     (sample_in),
    .enable        (enable),
    .pdm_out       (pdm_out),
    .sample_strobe (sample_strobe),
    .state         (state)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] tag;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   tag_n = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops one expected state; strobes are 1 clk wide.
  exp_t mon_e;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (sample_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe (state %0d), expected none", state);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("strobe_state[%0d]", mon_e.tag), int'(state), int'(mon_e.st));
      end
    end
    if (prev_strobe) check("strobe_width", int'(sample_strobe), 0);
    prev_strobe = sample_strobe;
  end

  int ones;
  int strobes_seen;
  int bad_pos;
  bit count_on = 1'b0;
  int cnt_from = 0;

  // One sample period starting at a negedge: hi clks high, lo clks low.
  // The strobe must appear at the first negedge after the rise (i == 0).
  task automatic period(input int hi, input int lo, input logic [1:0] st);
    exp_q.push_back('{tag: tag_n, st: st});
    tag_n++;
    sample_clock = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (sample_strobe) begin
        strobes_seen++;
        if (i != 0) bad_pos++;
      end
      if (count_on && i >= cnt_from) ones += int'(pdm_out);
      if (i == hi - 1) sample_clock = 1'b0;
    end
  endtask

  int held;

  initial begin
    // ---- 1: reset, muted, midscale alternation --------------------------------
    rst          = 1'b1;
    enable       = 1'b0;
    sample_in    = 14'd16383;
    sample_clock = 1'b1;            // high at release -> tick on first clk
    #2;
    check("reset_pdm", int'(pdm_out), 0);
    check("reset_state", int'(state), 0);
    check("reset_strobe", int'(sample_strobe), 0);
    repeat (3) @(negedge clk);
    exp_q.push_back('{tag: tag_n, st: 2'd0});
    tag_n++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("first_clk_strobe", int'(sample_strobe), 1);
      // midscale 8192 from acc=0: carry every second clk, starting with 0
      check($sformatf("mid_pdm[%0d]", i), int'(pdm_out), i % 2);
    end
    repeat (120) @(negedge clk);
    sample_clock = 1'b0;
    repeat (128) @(negedge clk);
    ones = 0; cnt_from = 0; count_on = 1'b1;
    period(128, 128, 2'd0);
    period(128, 128, 2'd0);
    count_on = 1'b0;
    check("mid_density_512", ones, 256);

    // ---- 2: ramp up to unity, full-scale density ------------------------------
    enable = 1'b1;
    @(negedge clk);
    check("enter_ramp_up", int'(state), 1);
    for (int k = 1; k <= 256; k++) period(8, 8, (k < 256) ? 2'd1 : 2'd2);
    period(8, 8, 2'd2);
    ones = 0; cnt_from = 0; count_on = 1'b1;
    for (int k = 0; k < 1024; k++) period(8, 8, 2'd2);
    count_on = 1'b0;
    check("full_density_16384", ones, 16383);

    // ---- 3: zero sample while playing -----------------------------------------
    sample_in = '0;
    ones = 0; cnt_from = 1; count_on = 1'b1;   // dac is 0 from the clk after the tick
    period(8, 8, 2'd2);
    cnt_from = 0;
    period(128, 128, 2'd2);
    count_on = 1'b0;
    check("zero_sample_ones", ones, 0);

    // ---- 4: ramp down, partial ramp, reversal at gain 100 ---------------------
    sample_in = 14'd16383;
    enable = 1'b0;
    @(negedge clk);
    check("enter_ramp_down", int'(state), 3);
    for (int k = 1; k <= 256; k++) period(8, 8, (k < 256) ? 2'd3 : 2'd0);
    enable = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 100; k++) period(8, 8, 2'd1);
    enable = 1'b0;
    @(negedge clk);
    check("reverse_at_100", int'(state), 3);
    for (int k = 1; k <= 100; k++) period(8, 8, (k < 100) ? 2'd3 : 2'd0);
    period(8, 8, 2'd0);

    // ---- 5: sample_clock held high, then toggling -----------------------------
    exp_q.push_back('{tag: tag_n, st: 2'd0});
    tag_n++;
    sample_clock = 1'b1;
    held = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sample_strobe) held++;
    end
    check("held_high_strobes", held, 1);
    sample_clock = 1'b0;
    repeat (128) @(negedge clk);
    strobes_seen = 0; bad_pos = 0;
    for (int k = 0; k < 3; k++) period(128, 128, 2'd0);
    check("toggle_strobes", strobes_seen, 3);
    check("strobe_position", bad_pos, 0);

    // ---- 6: asynchronous reset in the middle of PLAYING -----------------------
    enable = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 256; k++) period(8, 8, (k < 256) ? 2'd1 : 2'd2);
    period(8, 8, 2'd2);
    check("playing_before_reset", int'(state), 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pdm", int'(pdm_out), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_strobe", int'(sample_strobe), 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_state", int'(state), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
